// File: rtl/jcs_front_panel.sv
// jcs_front_panel: button-driven run/pause/step/load sequencer that gates the jcscpu clock on instruction boundaries
module jcs_front_panel #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter bit AUTORUN = 1'b1
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_load,
  input  logic [15:0] sw,
  input  logic        halt,
  input  logic        stp_first,
  input  logic        cpu_quiet,
  output logic        cpu_clk_en,
  output logic [7:0]  ld_bus,
  output logic        ld_mar_s,
  output logic        ld_ram_s,
  output logic [1:0]  mode,
  output logic [15:0] instr_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [3:0] {
    RUN, STOPPING, STEPPING, PAUSED, LD_MAR, LD_MAR_HOLD, LD_DATA, LD_DATA_HOLD, HALTED
  } state_t;
  state_t state, state_n;
  logic [2:0] btn, sync1, sync2, deb, ev;
  logic [CW-1:0] cnt [3];
  logic armed, boundary, ret_halt, active, stopping, run_ev, step_ev, load_ev;
  assign btn = {btn_load, btn_step, btn_run};
  assign run_ev = ev[0];
  assign step_ev = ev[1];
  assign load_ev = ev[2];
  // two-flop synchronizer for the raw buttons
  always_ff @(posedge sclk) begin
    sync1 <= reset ? 3'b000 : btn;
    sync2 <= reset ? 3'b000 : sync1;
  end
  // debounce each button and emit a one-cycle event on an accepted rising level
  always_ff @(posedge sclk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        cnt[i] <= '0;
        deb[i] <= 1'b0;
        ev[i]  <= 1'b0;
      end else if (sync2[i] != deb[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt[i] <= '0;
        deb[i] <= sync2[i];
        ev[i]  <= sync2[i];
      end else begin
        cnt[i] <= (sync2[i] != deb[i]) ? cnt[i] + 1'b1 : '0;
        ev[i]  <= 1'b0;
      end
    end
  end
  assign boundary = armed & stp_first & cpu_quiet;
  assign active = state == RUN || state == STOPPING || state == STEPPING;
  assign stopping = state == STOPPING || state == STEPPING;
  assign cpu_clk_en = ~reset & active & ~halt & ~(boundary & stopping);
  // arm once the CPU has left step 1, and count every boundary crossed
  always_ff @(posedge sclk) begin
    if (reset) begin
      armed <= 1'b0;
      instr_count <= '0;
    end else begin
      armed <= boundary ? 1'b0 : (~stp_first & cpu_clk_en) ? 1'b1 : armed;
      instr_count <= boundary ? instr_count + 1'b1 : instr_count;
    end
  end
  // state register; ret_halt remembers whether a load came from HALTED
  always_ff @(posedge sclk) begin
    if (reset) begin
      state <= AUTORUN ? RUN : PAUSED;
      ret_halt <= 1'b0;
    end else begin
      state <= state_n;
      ret_halt <= (state == HALTED) ? 1'b1 : (state == PAUSED) ? 1'b0 : ret_halt;
    end
  end
  // next-state and load-sequence outputs
  always_comb begin
    state_n = state;
    ld_bus = 8'h00;
    ld_mar_s = 1'b0;
    ld_ram_s = 1'b0;
    mode = 2'd0;
    case (state)
      RUN:          state_n = halt ? HALTED : run_ev ? STOPPING : RUN;
      STOPPING:     state_n = halt ? HALTED : boundary ? PAUSED : run_ev ? RUN : STOPPING;
      STEPPING:     state_n = halt ? HALTED : boundary ? PAUSED : STEPPING;
      PAUSED:       state_n = run_ev ? RUN : step_ev ? STEPPING : load_ev ? LD_MAR : PAUSED;
      LD_MAR:       state_n = LD_MAR_HOLD;
      LD_MAR_HOLD:  state_n = LD_DATA;
      LD_DATA:      state_n = LD_DATA_HOLD;
      LD_DATA_HOLD: state_n = ret_halt ? HALTED : PAUSED;
      HALTED:       state_n = load_ev ? LD_MAR : HALTED;
      default:      state_n = AUTORUN ? RUN : PAUSED;
    endcase
    if (!reset) begin
      ld_bus = (state == LD_MAR || state == LD_MAR_HOLD) ? sw[15:8] :
               (state == LD_DATA || state == LD_DATA_HOLD) ? sw[7:0] : 8'h00;
      ld_mar_s = state == LD_MAR;
      ld_ram_s = state == LD_DATA;
    end
    mode = (state == PAUSED) ? 2'd1 : (state == HALTED) ? 2'd3 :
           (state == LD_MAR || state == LD_MAR_HOLD || state == LD_DATA || state == LD_DATA_HOLD) ? 2'd2 : 2'd0;
  end
endmodule

// File: tb/tb_jcs_front_panel.sv
// tb_jcs_front_panel: directed checks of the front panel against a 6-step stepper and RAM model
module tb_jcs_front_panel;
  logic        sclk, reset, btn_run, btn_step, btn_load, halt, stp_first, cpu_quiet;
  logic [15:0] sw;
  logic        cpu_clk_en, ld_mar_s, ld_ram_s;
  logic [7:0]  ld_bus;
  logic [1:0]  mode;
  logic [15:0] instr_count;
  logic [4:0]  c;
  logic [7:0]  mar;
  logic [7:0]  mem [256];
  int total = 0;
  int bad = 0;

  jcs_front_panel #(.DEBOUNCE_CYCLES(3), .AUTORUN(1'b0)) dut (
    .sclk(sclk), .reset(reset), .btn_run(btn_run), .btn_step(btn_step), .btn_load(btn_load),
    .sw(sw), .halt(halt), .stp_first(stp_first), .cpu_quiet(cpu_quiet),
    .cpu_clk_en(cpu_clk_en), .ld_bus(ld_bus), .ld_mar_s(ld_mar_s), .ld_ram_s(ld_ram_s),
    .mode(mode), .instr_count(instr_count)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // stepper: 6 steps of 4 gated clocks each; quiet on the first clock of every step
  always @(posedge sclk) c <= reset ? 5'd0 : cpu_clk_en ? ((c == 5'd23) ? 5'd0 : c + 5'd1) : c;
  assign stp_first = c < 5'd4;
  assign cpu_quiet = c[1:0] == 2'd0;

  // RAM with MAR, written by the load strobes
  always @(posedge sclk) begin
    if (ld_mar_s) mar <= ld_bus;
    if (ld_ram_s) mem[mar] <= ld_bus;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sclk);
    #1;
  endtask

  task automatic press(input logic [2:0] b);
    {btn_load, btn_step, btn_run} = b;
    cyc(6);
    {btn_load, btn_step, btn_run} = 3'b000;
  endtask

  initial begin
    reset = 1'b1; {btn_load, btn_step, btn_run} = 3'b000; sw = 16'h0000; halt = 1'b0;
    cyc(2);
    chk("rst_en_held", cpu_clk_en, 0);
    reset = 1'b0;
    cyc(1);
    chk("rst_mode", mode, 1);
    chk("rst_en", cpu_clk_en, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_bus", ld_bus, 0);
    chk("rst_mar_s", ld_mar_s, 0);
    chk("rst_ram_s", ld_ram_s, 0);
    btn_step = 1'b1; cyc(2); btn_step = 1'b0; cyc(8);
    chk("glitch_mode", mode, 1);
    chk("glitch_en", cpu_clk_en, 0);
    press(3'b010);
    chk("step_mode", mode, 0);
    chk("step_en", cpu_clk_en, 1);
    cyc(23);
    chk("step_mid_en", cpu_clk_en, 1);
    cyc(1);
    chk("step_stop_en", cpu_clk_en, 0);
    chk("step_cnt_pre", instr_count, 0);
    cyc(1);
    chk("step_done_mode", mode, 1);
    chk("step_cnt", instr_count, 1);
    cyc(5);
    sw = 16'h2A5C;
    press(3'b100);
    chk("ld_mar_mode", mode, 2);
    chk("ld_mar_bus", ld_bus, 16'h2A);
    chk("ld_mar_s", ld_mar_s, 1);
    chk("ld_mar_ram_s", ld_ram_s, 0);
    cyc(1);
    chk("ld_mh_bus", ld_bus, 16'h2A);
    chk("ld_mh_mar_s", ld_mar_s, 0);
    cyc(1);
    chk("ld_d_bus", ld_bus, 16'h5C);
    chk("ld_d_ram_s", ld_ram_s, 1);
    chk("ld_d_mar_s", ld_mar_s, 0);
    cyc(1);
    chk("ld_dh_bus", ld_bus, 16'h5C);
    chk("ld_dh_ram_s", ld_ram_s, 0);
    cyc(1);
    chk("ld_end_mode", mode, 1);
    chk("ld_end_bus", ld_bus, 0);
    chk("ld_ram", mem[8'h2A], 16'h5C);
    cyc(5);
    btn_run = 1'b1;
    cyc(5);
    chk("run_lat_mode", mode, 1);
    cyc(1);
    btn_run = 1'b0;
    chk("run_mode", mode, 0);
    chk("run_en", cpu_clk_en, 1);
    cyc(4);
    press(3'b100);
    chk("run_load_mode", mode, 0);
    chk("run_load_bus", ld_bus, 0);
    chk("run_load_en", cpu_clk_en, 1);
    cyc(14);
    chk("run_bnd_en", cpu_clk_en, 1);
    cyc(1);
    chk("run_cnt", instr_count, 2);
    press(3'b001);
    chk("stopping_mode", mode, 0);
    chk("stopping_en", cpu_clk_en, 1);
    cyc(4);
    press(3'b001);
    chk("resume_mode", mode, 0);
    chk("resume_en", cpu_clk_en, 1);
    cyc(7);
    chk("resume_bnd_en", cpu_clk_en, 1);
    cyc(1);
    chk("resume_cnt", instr_count, 3);
    press(3'b001);
    cyc(16);
    chk("pause_mid_en", cpu_clk_en, 1);
    cyc(1);
    chk("pause_bnd_en", cpu_clk_en, 0);
    chk("pause_bnd_mode", mode, 0);
    cyc(1);
    chk("pause_mode", mode, 1);
    chk("pause_cnt", instr_count, 4);
    cyc(4);
    press(3'b001);
    cyc(2);
    halt = 1'b1;
    #1;
    chk("halt_en_now", cpu_clk_en, 0);
    cyc(1);
    halt = 1'b0;
    #1;
    chk("halt_mode", mode, 3);
    chk("halt_en", cpu_clk_en, 0);
    cyc(4);
    press(3'b001);
    chk("halt_run_mode", mode, 3);
    cyc(4);
    press(3'b010);
    chk("halt_step_mode", mode, 3);
    chk("halt_step_en", cpu_clk_en, 0);
    cyc(4);
    sw = 16'h1733;
    press(3'b100);
    chk("hld_mode", mode, 2);
    chk("hld_mar_bus", ld_bus, 16'h17);
    chk("hld_mar_s", ld_mar_s, 1);
    cyc(2);
    chk("hld_d_bus", ld_bus, 16'h33);
    chk("hld_ram_s", ld_ram_s, 1);
    cyc(2);
    chk("hld_end_mode", mode, 3);
    chk("hld_ram", mem[8'h17], 16'h33);
    chk("hld_cnt", instr_count, 4);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    #1;
    chk("rst2_mode", mode, 1);
    chk("rst2_cnt", instr_count, 0);
    force dut.instr_count = 16'hFFFE;
    press(3'b010);
    cyc(25);
    chk("wrap_pre_mode", mode, 1);
    force dut.instr_count = 16'hFFFF;
    release dut.instr_count;
    #1;
    chk("wrap_preset", instr_count, 16'hFFFF);
    cyc(4);
    press(3'b010);
    cyc(25);
    chk("wrap_cnt", instr_count, 16'h0000);
    chk("wrap_mode", mode, 1);
    cyc(4);
    press(3'b111);
    chk("all3_mode", mode, 0);
    chk("all3_en", cpu_clk_en, 1);
    cyc(24);
    chk("all3_bnd_en", cpu_clk_en, 1);
    cyc(1);
    chk("all3_cnt", instr_count, 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(4);
    sw = 16'h2A5C;
    press(3'b100);
    cyc(2);
    chk("rld_pre_ram_s", ld_ram_s, 1);
    reset = 1'b1;
    #1;
    chk("rld_ram_s", ld_ram_s, 0);
    chk("rld_bus", ld_bus, 0);
    chk("rld_en", cpu_clk_en, 0);
    cyc(1);
    reset = 1'b0;
    #1;
    chk("rld_mode", mode, 1);
    chk("rld_bus_after", ld_bus, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
